mpmc10_app_cmd_seq: RTL
=======================

Name: mpmc10_app_cmd_seq

Overview:
- Sequences one memory transaction at a time onto the MIG user interface for the mpmc10 controller.
- Drives the command/address channel (app_en, app_cmd, app_addr) and the write-data FIFO channel (app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask), honouring app_rdy and app_wdf_rdy independently.
- Sits between the port arbiter (upstream, req/ack/done) and the MIG UI. Replaces fixed-state write-strobe generation with handshake-driven sequencing plus a stall timeout.

Parameters:
AW, 29, MIG app_addr width
DW, 128, app_wdf_data width per beat
BEATS, 1, wdf beats per command (1 for 4:1 mode, 2 for 2:1 mode); legal values 1..4
TIMEOUT, 1023, max cycles without any handshake before abort; 0 disables the timeout

Ports:
clk  in  1  UI clock
rst_n  in  1  asynchronous active-low reset
calib_done  in  1  MIG init_calib_complete
req  in  1  arbiter request, held until ack
req_we  in  1  1=write, 0=read
req_adr  in  AW  command address
req_dat  in  DW*BEATS  write data; beat 0 in LSBs
req_sel  in  DW/8*BEATS  byte enables, active high
ack  out  1  request captured (1-cycle pulse)
done  out  1  transaction handed to MIG (1-cycle pulse)
err  out  1  timeout abort (1-cycle pulse)
busy  out  1  state != IDLE
app_en  out  1  command valid
app_cmd  out  3  3'b000 write, 3'b001 read
app_addr  out  AW  command address
app_rdy  in  1  MIG command accept
app_wdf_data  out  DW  write beat data
app_wdf_mask  out  DW/8  byte mask, active high = masked (~sel)
app_wdf_wren  out  1  write beat valid
app_wdf_end  out  1  last beat of the command
app_wdf_rdy  in  1  MIG write FIFO accept

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on rst_n. All outputs are registered.
- Reset values: all 1-bit outputs 0; app_cmd=3'b001; app_addr, app_wdf_data and app_wdf_mask 0; state IDLE; beat counter 0; timeout counter 0.
- States: IDLE, XFER, DONE.
- IDLE:
  - Transition occurs when req && calib_done is sampled at edge N.
  - Captures req_we, req_adr, req_dat and req_sel.
  - In cycle N+1: ack=1, app_en=1, app_addr and app_cmd valid. If the request is a write, app_wdf_wren=1 with beat 0, and app_wdf_end=(BEATS==1).
  - Next state is XFER.
  - req without calib_done: no ack, remain in IDLE.
- XFER:
  - Command channel: app_en stays high until an edge sees app_en && app_rdy; it is 0 in the following cycle. cmd_ok is set.
  - Data channel (write only): on an edge with app_wdf_wren && app_wdf_rdy, advance the beat.
    - app_wdf_data and app_wdf_mask update to the next beat in the next cycle.
    - app_wdf_end is high exactly while the last beat is presented.
    - After the last beat is accepted, app_wdf_wren=0 and dat_ok is set.
  - The two channels run concurrently. Data may complete before or after the command.
  - Read: dat_ok is forced to 1 at entry.
  - When cmd_ok && dat_ok are both true → DONE. A simultaneous final command and final data handshake on the same edge is legal and goes to DONE directly.
- DONE: done=1 for one cycle, then IDLE. A new req is sampled no earlier than the DONE→IDLE edge, so the next ack comes 2 cycles after done at the earliest.
- Timeout counter:
  - Clears on entering XFER and on any handshake. Otherwise it increments while in XFER.
  - When count == TIMEOUT (TIMEOUT != 0): the next cycle has app_en=0, app_wdf_wren=0 and app_wdf_end=0, err=1 for one cycle, done=0, and the state goes to IDLE.
  - Counter width is clog2(TIMEOUT+1). It saturates and never wraps.
- calib_done falling mid-transaction does not affect the transaction in flight; it only gates acceptance in IDLE.
- rst_n asserted mid-transaction forces reset values immediately. No partial-command recovery.
- ack, done and err are mutually exclusive in any cycle.

Test Plan:
1. Read with app_rdy=1 throughout, req_adr=29'h0001_2340.
   - Required: ack and app_en high in cycle N+1 with app_cmd=001 and app_addr=0001_2340; done in cycle N+2; app_wdf_wren never asserted.
2. Write with BEATS=2, app_rdy held low 3 cycles, app_wdf_rdy=1.
   - Required: both beats accepted on consecutive edges, and wdf_end high only on beat 1.
   - Required: app_en held 4 cycles; done in the cycle after app_rdy is sampled high.
3. Write with BEATS=1 and req_sel=16'h00FF.
   - Required: app_wdf_mask=16'hFF00.
   - Required: app_wdf_rdy low 2 cycles while app_rdy=1. The command completes first; done comes only after the data handshake.
4. TIMEOUT=8 and app_rdy stuck low.
   - Required: err pulse 9 cycles after ack; app_en low in the err cycle; no done; busy=0 after the err cycle; the next req is acked normally.
5. req with calib_done=0 for 5 cycles, then calib_done=1.
   - Required: no ack until the cycle after calib_done is sampled high.
6. rst_n pulsed low while in XFER of a write.
   - Required: app_en, app_wdf_wren and busy go 0 immediately without waiting for clk; no done and no err; after release, a read completes normally.

Source files
------------

// File: rtl/mpmc10_app_cmd_seq.sv
// mpmc10_app_cmd_seq: issues one arbiter transaction at a time onto the MIG UI
// command and write-data channels, aborting if neither channel makes progress.
module mpmc10_app_cmd_seq #(
  parameter int AW      = 29,
  parameter int DW      = 128,
  parameter int BEATS   = 1,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  calib_done,
  input  logic                  req,
  input  logic                  req_we,
  input  logic [AW-1:0]         req_adr,
  input  logic [DW*BEATS-1:0]   req_dat,
  input  logic [DW/8*BEATS-1:0] req_sel,
  output logic                  ack,
  output logic                  done,
  output logic                  err,
  output logic                  busy,
  output logic                  app_en,
  output logic [2:0]            app_cmd,
  output logic [AW-1:0]         app_addr,
  input  logic                  app_rdy,
  output logic [DW-1:0]         app_wdf_data,
  output logic [DW/8-1:0]       app_wdf_mask,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  input  logic                  app_wdf_rdy
);

  // state | meaning
  // IDLE  | waiting for req while calibration is complete
  // XFER  | command and/or write beats outstanding on the MIG UI
  // DONE  | transaction handed to the MIG, done pulse showing
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;

  localparam int MW = DW / 8;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t state, state_d;

  logic [DW*BEATS-1:0] dat_q;
  logic [MW*BEATS-1:0] sel_q;
  logic [BW-1:0]       beat;
  logic [TW-1:0]       tmo_cnt;
  logic                cmd_ok, dat_ok;

  logic start, cmd_hs, dat_hs, last_hs, cmd_ok_d, dat_ok_d, fin, tmo_hit;

  logic            ack_d, done_d, err_d, app_en_d, app_wdf_wren_d, app_wdf_end_d;
  logic [2:0]      app_cmd_d;
  logic [AW-1:0]   app_addr_d;
  logic [DW-1:0]   app_wdf_data_d;
  logic [MW-1:0]   app_wdf_mask_d;

  assign start    = (state == IDLE) && req && calib_done;
  assign cmd_hs   = app_en && app_rdy;
  assign dat_hs   = app_wdf_wren && app_wdf_rdy;
  assign last_hs  = dat_hs && (beat == BW'(BEATS - 1));
  assign cmd_ok_d = cmd_ok || cmd_hs;
  assign dat_ok_d = dat_ok || last_hs;
  assign fin      = (state == XFER) && cmd_ok_d && dat_ok_d;
  // Any handshake on the terminal-count edge counts as progress and wins.
  assign tmo_hit  = (TIMEOUT != 0) && (state == XFER) && !fin && !cmd_hs && !dat_hs &&
                    (tmo_cnt == TW'(TIMEOUT));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = XFER;
      XFER: begin
        if (fin)          state_d = DONE;
        else if (tmo_hit) state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_d          = 1'b0;
    done_d         = 1'b0;
    err_d          = 1'b0;
    app_en_d       = app_en;
    app_cmd_d      = app_cmd;
    app_addr_d     = app_addr;
    app_wdf_wren_d = app_wdf_wren;
    app_wdf_end_d  = app_wdf_end;
    app_wdf_data_d = app_wdf_data;
    app_wdf_mask_d = app_wdf_mask;
    case (state)
      IDLE: begin
        if (start) begin
          ack_d          = 1'b1;
          app_en_d       = 1'b1;
          app_cmd_d      = req_we ? 3'b000 : 3'b001;
          app_addr_d     = req_adr;
          app_wdf_wren_d = req_we;
          app_wdf_end_d  = req_we && (BEATS == 1);
          app_wdf_data_d = req_dat[DW-1:0];
          app_wdf_mask_d = ~req_sel[MW-1:0];
        end
      end
      XFER: begin
        if (cmd_hs) app_en_d = 1'b0;
        if (last_hs) begin
          app_wdf_wren_d = 1'b0;
          app_wdf_end_d  = 1'b0;
        end else if (dat_hs) begin
          app_wdf_data_d = DW'(dat_q >> (DW * (int'(beat) + 1)));
          app_wdf_mask_d = ~MW'(sel_q >> (MW * (int'(beat) + 1)));
          app_wdf_end_d  = (int'(beat) + 2 == BEATS);
        end
        if (fin) begin
          done_d = 1'b1;
        end else if (tmo_hit) begin
          err_d          = 1'b1;
          app_en_d       = 1'b0;
          app_wdf_wren_d = 1'b0;
          app_wdf_end_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack          <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      app_en       <= 1'b0;
      app_cmd      <= 3'b001;
      app_addr     <= '0;
      app_wdf_wren <= 1'b0;
      app_wdf_end  <= 1'b0;
      app_wdf_data <= '0;
      app_wdf_mask <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      beat         <= '0;
      cmd_ok       <= 1'b0;
      dat_ok       <= 1'b0;
      tmo_cnt      <= '0;
    end else begin
      ack          <= ack_d;
      done         <= done_d;
      err          <= err_d;
      app_en       <= app_en_d;
      app_cmd      <= app_cmd_d;
      app_addr     <= app_addr_d;
      app_wdf_wren <= app_wdf_wren_d;
      app_wdf_end  <= app_wdf_end_d;
      app_wdf_data <= app_wdf_data_d;
      app_wdf_mask <= app_wdf_mask_d;
      if (start) begin
        dat_q   <= req_dat;
        sel_q   <= req_sel;
        beat    <= '0;
        cmd_ok  <= 1'b0;
        dat_ok  <= !req_we;
        tmo_cnt <= '0;
      end else if (state == XFER) begin
        cmd_ok <= cmd_ok_d;
        dat_ok <= dat_ok_d;
        if (dat_hs && !last_hs) beat <= beat + 1'b1;
        if (cmd_hs || dat_hs)      tmo_cnt <= '0;
        else if (tmo_cnt != '1)    tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

endmodule
